// File: rtl/tx_packet_scheduler_if.sv
// Command/encoder handshake bundle between the TX register block, the scheduler and the TX encoder.
// OCC_W sets the width of the data-buffer occupancy count.
interface tx_packet_scheduler_if #(
    parameter int unsigned OCC_W = 7
);
    logic             cmd_valid;
    logic [2:0]       cmd_code;
    logic             cmd_ready;
    logic             abort;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             tx_transfer_active;
    logic             tx_error;
    logic             tx_start;
    logic [1:0]       tx_packet;
    logic             busy;
    logic             cmd_done;
    logic [2:0]       cmd_status;

    modport master (
        output cmd_valid, cmd_code, abort, buffer_occupancy, tx_transfer_active, tx_error,
        input  cmd_ready, tx_start, tx_packet, busy, cmd_done, cmd_status
    );

    modport slave (
        input  cmd_valid, cmd_code, abort, buffer_occupancy, tx_transfer_active, tx_error,
        output cmd_ready, tx_start, tx_packet, busy, cmd_done, cmd_status
    );
endinterface

// File: rtl/tx_packet_scheduler.sv
// USB TX packet scheduler: runs one TX command at a time through the packet encoder with retry,
// watchdog timeout and abort, and reports a one-cycle completion pulse with a held status.
module tx_packet_scheduler #(
    parameter int unsigned TIMEOUT_W   = 10,
    parameter int unsigned MAX_RETRIES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_packet_scheduler_if.slave bus
);
    localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [TIMEOUT_W-1:0] TIMER_MAX = '1;

    localparam logic [2:0] CODE_DATA = 3'd1;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_TX_ERR  = 3'd1;
    localparam logic [2:0] ST_TIMEOUT = 3'd2;
    localparam logic [2:0] ST_REJECT  = 3'd3;
    localparam logic [2:0] ST_ABORTED = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        START,
        WAIT_ACTIVE,
        WAIT_DONE,
        DONE
    } state_t;

    state_t               state;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [TIMEOUT_W-1:0] timer;
    logic [2:0]           code_reg;
    logic [TIMEOUT_W-1:0] timer_inc;
    logic                 timer_expired;

    // Watchdog counts cycles since tx_start (or since active rose) and sticks at its maximum.
    assign timer_expired = (timer == TIMER_MAX);
    assign timer_inc     = timer_expired ? timer : timer + TIMEOUT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            retry_cnt      <= '0;
            timer          <= '0;
            code_reg       <= '0;
            bus.cmd_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.tx_start   <= 1'b0;
            bus.tx_packet  <= 2'b00;
            bus.cmd_done   <= 1'b0;
            bus.cmd_status <= ST_OK;
        end else begin
            bus.tx_start <= 1'b0;
            bus.cmd_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid && (bus.cmd_code != 3'd0)) begin
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.cmd_code <= 3'd4) begin
                            code_reg  <= bus.cmd_code;
                            retry_cnt <= '0;
                            state     <= CHECK;
                        end else begin
                            state          <= DONE;
                            bus.cmd_done   <= 1'b1;
                            bus.cmd_status <= ST_REJECT;
                        end
                    end
                end
                CHECK: begin
                    if (bus.abort) begin
                        state          <= DONE;
                        bus.cmd_done   <= 1'b1;
                        bus.cmd_status <= ST_ABORTED;
                    end else if ((code_reg == CODE_DATA) && (bus.buffer_occupancy == '0)) begin
                        state          <= DONE;
                        bus.cmd_done   <= 1'b1;
                        bus.cmd_status <= ST_REJECT;
                    end else if (!bus.tx_transfer_active) begin
                        state         <= START;
                        bus.tx_start  <= 1'b1;
                        bus.tx_packet <= 2'(code_reg - 3'd1);
                        timer         <= '0;
                    end
                end
                START: begin
                    if (bus.abort) begin
                        state          <= DONE;
                        bus.cmd_done   <= 1'b1;
                        bus.cmd_status <= ST_ABORTED;
                        bus.tx_packet  <= 2'b00;
                    end else begin
                        state <= WAIT_ACTIVE;
                        timer <= timer_inc;
                    end
                end
                WAIT_ACTIVE: begin
                    if (bus.abort) begin
                        state          <= DONE;
                        bus.cmd_done   <= 1'b1;
                        bus.cmd_status <= ST_ABORTED;
                        bus.tx_packet  <= 2'b00;
                    end else if (bus.tx_transfer_active) begin
                        state <= WAIT_DONE;
                        timer <= '0;
                    end else if (timer_expired) begin
                        state          <= DONE;
                        bus.cmd_done   <= 1'b1;
                        bus.cmd_status <= ST_TIMEOUT;
                        bus.tx_packet  <= 2'b00;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                WAIT_DONE: begin
                    // Error wins over a simultaneous fall of active; a retry skips the occupancy check.
                    if (bus.abort) begin
                        state          <= DONE;
                        bus.cmd_done   <= 1'b1;
                        bus.cmd_status <= ST_ABORTED;
                        bus.tx_packet  <= 2'b00;
                    end else if (bus.tx_error) begin
                        if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
                            retry_cnt    <= retry_cnt + RETRY_W'(1);
                            state        <= START;
                            bus.tx_start <= 1'b1;
                            timer        <= '0;
                        end else begin
                            state          <= DONE;
                            bus.cmd_done   <= 1'b1;
                            bus.cmd_status <= ST_TX_ERR;
                            bus.tx_packet  <= 2'b00;
                        end
                    end else if (!bus.tx_transfer_active) begin
                        state          <= DONE;
                        bus.cmd_done   <= 1'b1;
                        bus.cmd_status <= ST_OK;
                        bus.tx_packet  <= 2'b00;
                    end else if (timer_expired) begin
                        state          <= DONE;
                        bus.cmd_done   <= 1'b1;
                        bus.cmd_status <= ST_TIMEOUT;
                        bus.tx_packet  <= 2'b00;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.tx_packet <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Bench for tx_packet_scheduler: directed scenarios plus randomized commands against a
// cycle-arithmetic reference model and a scripted TX encoder responder.
module tb_tx_packet_scheduler;
    localparam int unsigned OCC_W       = 7;
    localparam int          MAX_RETRIES = 3;
    localparam int          TIMEOUT_CYC = 1024;

    logic clk;
    logic rst;

    tx_packet_scheduler_if #(.OCC_W(OCC_W)) bus ();

    tx_packet_scheduler #(
        .TIMEOUT_W  (10),
        .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         got_start[$];
    logic [1:0] got_pkt[$];
    int         exp_start[$];
    int         att_d[8];
    int         att_l[8];
    bit         att_e[8];
    int         rise_at = -1;
    int         fall_at = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every start strobe and completion pulse with the cycle it appeared in.
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            got_start.push_back(cyc);
            got_pkt.push_back(bus.tx_packet);
        end
        if (bus.cmd_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    // Encoder: attempt k raises active att_d[k] cycles after its start (0 = never), holds it
    // att_l[k] cycles, and pulses tx_error on the falling cycle when att_e[k] is set.
    initial begin : encoder
        int idx;
        idx = 0;
        bus.tx_transfer_active = 1'b0;
        bus.tx_error = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_error = 1'b0;
            if (cyc == rise_at) bus.tx_transfer_active = 1'b1;
            if (cyc == fall_at) begin
                bus.tx_transfer_active = 1'b0;
                bus.tx_error = att_e[idx == 0 ? 0 : idx - 1];
            end
            if (bus.cmd_ready === 1'b1) idx = 0;
            if (bus.tx_start === 1'b1) begin
                if (att_d[idx] == 0) begin
                    rise_at = -1;
                    fall_at = -1;
                end else begin
                    rise_at = cyc + att_d[idx];
                    fall_at = rise_at + att_l[idx];
                end
                if (idx < 7) idx++;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: observed still running at time limit, expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_script();
        for (int k = 0; k < 8; k++) begin
            att_d[k] = 1;
            att_l[k] = 1;
            att_e[k] = 1'b0;
        end
    endtask

    task automatic script(input int k, input int d, input int l, input bit e);
        att_d[k] = d;
        att_l[k] = l;
        att_e[k] = e;
    endtask

    // Expected start cycles, completion cycle and status from the command rules and encoder script.
    function automatic void model(input logic [2:0] code, input logic [6:0] occ, input int n,
                                  input int abort_off, output int st, output int dn, output int ab);
        int s;
        int e;
        exp_start.delete();
        st = 0;
        dn = 0;
        ab = -1;
        if (code >= 3'd5) begin
            st = 3;
            dn = n + 1;
            return;
        end
        if (code == 3'd1 && occ == 7'd0) begin
            st = 3;
            dn = n + 2;
            return;
        end
        s = n + 2;
        for (int k = 0; k <= MAX_RETRIES; k++) begin
            exp_start.push_back(s);
            if (att_d[k] == 0) begin
                st = 2;
                dn = s + TIMEOUT_CYC;
                break;
            end
            e = s + att_d[k] + att_l[k];
            if (!att_e[k]) begin
                st = 0;
                dn = e + 1;
                break;
            end
            if (k == MAX_RETRIES) begin
                st = 1;
                dn = e + 1;
                break;
            end
            s = e + 1;
        end
        if (abort_off >= 0) begin
            ab = exp_start[0] + abort_off;
            if (ab < dn) begin
                st = 4;
                dn = ab + 1;
                while (exp_start.size() > 0 && exp_start[$] > ab) void'(exp_start.pop_back());
            end
        end
    endfunction

    task automatic wait_idle(input string tag);
        int budget;
        budget = 0;
        while (!(bus.cmd_ready === 1'b1 && cyc > rise_at && cyc > fall_at) && budget < 3000) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check({tag, "_idle_wait"}, 32'(budget < 3000), 32'd1);
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] code, input logic [6:0] occ,
                           input int abort_off);
        int n;
        int st;
        int dn;
        int ab;
        int base_s;
        int base_d;
        int budget;
        int n_got;
        wait_idle(tag);
        n = cyc;
        base_s = got_start.size();
        base_d = done_cnt;
        model(code, occ, n, abort_off, st, dn, ab);
        bus.cmd_code = code;
        bus.buffer_occupancy = occ;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_code = 3'd0;
        if (code == 3'd0) begin
            repeat (6) begin
                @(negedge clk);
                #1;
            end
            check({tag, "_noop_starts"}, 32'(got_start.size() - base_s), 32'd0);
            check({tag, "_noop_done"}, 32'(done_cnt - base_d), 32'd0);
            check({tag, "_noop_ready"}, 32'(bus.cmd_ready), 32'd1);
            return;
        end
        budget = 0;
        while (done_cnt == base_d && budget < 4000) begin
            bus.abort = (cyc == ab);
            @(negedge clk);
            #1;
            budget++;
        end
        bus.abort = 1'b0;
        check({tag, "_done_seen"}, 32'(done_cnt != base_d), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_cyc - n), 32'(dn - n));
        check({tag, "_status"}, 32'(bus.cmd_status), 32'(st));
        n_got = got_start.size() - base_s;
        check({tag, "_starts"}, 32'(n_got), 32'(exp_start.size()));
        for (int i = 0; i < exp_start.size() && i < n_got; i++) begin
            check({tag, "_start_cycle"}, 32'(got_start[base_s + i] - n), 32'(exp_start[i] - n));
            check({tag, "_packet"}, 32'(got_pkt[base_s + i]), 32'(2'(code - 3'd1)));
        end
        @(negedge clk);
        #1;
        check({tag, "_ready_after"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_status_held"}, 32'(bus.cmd_status), 32'(st));
        check({tag, "_single_done"}, 32'(done_cnt - base_d), 32'd1);
    endtask

    initial begin : main
        int n;
        int base_s;
        int base_d;
        logic [2:0] rcode;
        logic [6:0] rocc;
        int roff;

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_code = 3'd0;
        bus.abort = 1'b0;
        bus.buffer_occupancy = '0;
        clear_script();

        repeat (2) @(negedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_cmd_done", 32'(bus.cmd_done), 32'd0);
        check("rst_cmd_status", 32'(bus.cmd_status), 32'd0);
        check("rst_tx_packet", 32'(bus.tx_packet), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        clear_script();
        script(0, 2, 5, 1'b0);
        run_cmd("ack_ok", 3'd2, 7'd0, -1);

        clear_script();
        run_cmd("data_empty", 3'd1, 7'd0, -1);

        clear_script();
        for (int k = 0; k <= MAX_RETRIES; k++) script(k, 1, 3, 1'b1);
        run_cmd("nak_tx_err", 3'd3, 7'd0, -1);

        clear_script();
        script(0, 0, 1, 1'b0);
        run_cmd("stall_timeout", 3'd4, 7'd0, -1);

        clear_script();
        script(0, 1, 10, 1'b0);
        run_cmd("data_abort", 3'd1, 7'd64, 2);

        clear_script();
        run_cmd("noop", 3'd0, 7'd5, -1);

        // Abort while idle must be ignored.
        wait_idle("idle_abort");
        base_d = done_cnt;
        bus.abort = 1'b1;
        @(negedge clk);
        #1;
        bus.abort = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("idle_abort_ready", 32'(bus.cmd_ready), 32'd1);
        check("idle_abort_done", 32'(done_cnt - base_d), 32'd0);

        // Reset while waiting for the encoder to finish: back to idle, no completion pulse.
        clear_script();
        script(0, 1, 20, 1'b0);
        wait_idle("rst_mid");
        n = cyc;
        base_s = got_start.size();
        base_d = done_cnt;
        bus.cmd_code = 3'd1;
        bus.buffer_occupancy = 7'd64;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_code = 3'd0;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("rst_mid_started", 32'(got_start.size() - base_s), 32'd1);
        check("rst_mid_busy", 32'(bus.busy), 32'd1);
        check("rst_mid_cycle", 32'(cyc - n), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_mid_idle", 32'(bus.busy), 32'd0);
        repeat (30) begin
            @(negedge clk);
            #1;
        end
        check("rst_mid_no_done", 32'(done_cnt - base_d), 32'd0);

        clear_script();
        run_cmd("code6_reject", 3'd6, 7'd0, -1);

        for (int it = 0; it < 30; it++) begin
            clear_script();
            for (int k = 0; k <= MAX_RETRIES; k++) begin
                script(k, ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4)),
                       int'($urandom_range(1, 5)), ($urandom_range(0, 2) == 0));
            end
            rcode = 3'($urandom_range(0, 7));
            rocc  = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            roff  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_cmd("rand", rcode, rocc, roff);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
